// File: rtl/word_byte_unpacker.sv
// Streaming word-to-byte serializer: accepts one DATA_W-bit word on a valid/ready
// slave port and emits 1..NB of its bytes, MSB-first or LSB-first, one per cycle.
module word_byte_unpacker #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned NB    = DATA_W / 8,
    localparam int unsigned SEL_W = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_lsb_first,
    input  logic [SEL_W-1:0]  s_nbytes,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_data,
    output logic              m_last,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [SEL_W-1:0]    remain_q, remain_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   s_data_rev;
    logic                accept;
    logic                xfer;

    // Output slot is always shift_q[7:0]; MSB-first words are stored byte-reversed
    // so both orders drain with the same right shift.
    assign m_valid  = (state_q == SEND);
    assign m_last   = m_valid && (remain_q == '0);
    assign m_data   = shift_q[7:0];
    assign busy     = (state_q == SEND);
    assign word_cnt = cnt_q;
    assign s_ready  = (state_q == IDLE) || (m_last && m_ready);
    assign accept   = s_valid && s_ready;
    assign xfer     = m_valid && m_ready;

    // Byte-reverse the incoming word for MSB-first emission.
    always_comb begin
        s_data_rev = '0;
        for (int i = 0; i < int'(NB); i++) begin
            s_data_rev[i*8 +: 8] = s_data[(int'(NB) - 1 - i)*8 +: 8];
        end
    end

    // Next-state: drain on transfer, load a new word on accept (accept wins).
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        remain_d = remain_q;
        cnt_d    = cnt_q;
        if (xfer) begin
            shift_d  = shift_q >> 8;
            remain_d = remain_q - SEL_W'(1);
            if (m_last) begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = IDLE;
            end
        end
        if (accept) begin
            shift_d  = s_lsb_first ? s_data : s_data_rev;
            remain_d = s_nbytes;
            state_d  = SEND;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            remain_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            remain_q <= remain_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_word_byte_unpacker.sv
// Self-checking bench for word_byte_unpacker: table vectors, corner sequences,
// and randomized traffic against a byte-queue reference model.
module tb_word_byte_unpacker;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_lsb_first;
    logic [1:0]  s_nbytes;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic        busy;
    logic [15:0] word_cnt;

    word_byte_unpacker #(.DATA_W(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_lsb_first(s_lsb_first),
        .s_nbytes   (s_nbytes),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .word_cnt   (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending bytes of the held word as {last, byte}.
    logic [8:0]  model_q[$];
    logic [15:0] model_cnt = 16'h0;
    logic        after_rst = 1'b0;

    // Values sampled in the most recent cycle.
    logic        smp_valid, smp_last, smp_ready;
    logic [7:0]  smp_data;
    logic [15:0] smp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic cycle(input logic r, input logic sv, input logic [31:0] d,
                         input logic lsb, input logic [1:0] nb, input logic mr);
        logic exp_valid, exp_ready, exp_last;
        logic [7:0] exp_data;
        int idx;
        @(negedge clk);
        rst = r; s_valid = sv; s_data = d; s_lsb_first = lsb; s_nbytes = nb; m_ready = mr;
        #1;
        smp_valid = m_valid; smp_last = m_last; smp_ready = s_ready;
        smp_data = m_data; smp_cnt = word_cnt;
        exp_valid = (model_q.size() != 0);
        exp_last  = exp_valid ? model_q[0][8] : 1'b0;
        exp_data  = exp_valid ? model_q[0][7:0] : 8'h00;
        exp_ready = !exp_valid || (exp_last && mr);
        chk("m_valid", 32'(m_valid), 32'(exp_valid));
        chk("busy", 32'(busy), 32'(exp_valid));
        chk("s_ready", 32'(s_ready), 32'(exp_ready));
        chk("m_last", 32'(m_last), 32'(exp_last));
        chk("word_cnt", 32'(word_cnt), 32'(model_cnt));
        if (exp_valid || after_rst) chk("m_data", 32'(m_data), 32'(exp_data));
        if (r) begin
            model_q.delete();
            model_cnt = 16'h0;
            after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
            if (exp_valid && mr) begin
                void'(model_q.pop_front());
                if (exp_last) model_cnt = model_cnt + 16'h1;
            end
            if (sv && exp_ready) begin
                for (int i = 0; i <= int'(nb); i++) begin
                    idx = lsb ? i : 3 - i;
                    model_q.push_back({(i == int'(nb)), d[idx*8 +: 8]});
                end
            end
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic        lsb;
        logic [1:0]  nb;
        logic [31:0] exp;
        int          n;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [31:0] e;
        logic [15:0] cnt_start;
        int nv;

        tbl[0] = '{32'hA1B2C3D4, 1'b0, 2'd3, 32'hA1B2C3D4, 4};
        tbl[1] = '{32'hA1B2C3D4, 1'b1, 2'd3, 32'hD4C3B2A1, 4};
        tbl[2] = '{32'h11223344, 1'b0, 2'd1, 32'h11220000, 2};
        tbl[3] = '{32'hFF000000, 1'b0, 2'd0, 32'hFF000000, 1};
        tbl[4] = '{32'h12345678, 1'b1, 2'd2, 32'h78563400, 3};
        tbl[5] = '{32'hCAFE0042, 1'b1, 2'd0, 32'h42000000, 1};

        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_lsb_first = 1'b0; s_nbytes = '0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        after_rst = 1'b1;

        // Reset state.
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
        chk("rst_m_valid", 32'(smp_valid), 32'h0);
        chk("rst_s_ready", 32'(smp_ready), 32'h1);
        chk("rst_word_cnt", 32'(smp_cnt), 32'h0);
        chk("rst_m_data", 32'(smp_data), 32'h0);

        // Table vectors: one word each, m_ready held high.
        for (int k = 0; k < 6; k++) begin
            e = tbl[k].exp;
            cnt_start = model_cnt;
            cycle(1'b0, 1'b1, tbl[k].d, tbl[k].lsb, tbl[k].nb, 1'b1);
            chk("tbl_accept_ready", 32'(smp_ready), 32'h1);
            for (int j = 0; j < tbl[k].n; j++) begin
                cycle(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
                chk("tbl_valid", 32'(smp_valid), 32'h1);
                chk("tbl_byte", 32'(smp_data), 32'(e[31 - 8*j -: 8]));
                chk("tbl_last", 32'(smp_last), 32'(j == tbl[k].n - 1));
                if (j == tbl[k].n - 1) chk("tbl_ready_last", 32'(smp_ready), 32'h1);
            end
            cycle(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
            chk("tbl_idle_valid", 32'(smp_valid), 32'h0);
            chk("tbl_idle_ready", 32'(smp_ready), 32'h1);
            chk("tbl_cnt", 32'(smp_cnt), 32'(cnt_start + 16'h1));
        end

        // Back-to-back: three 4-byte words with s_valid held, no gaps.
        cnt_start = model_cnt;
        nv = 0;
        for (int c = 0; c < 14; c++) begin
            cycle(1'b0, (c < 9), 32'h0BADF00D + 32'(c), 1'b0, 2'd3, 1'b1);
            if (c >= 1 && c <= 12 && smp_valid) nv++;
            if (c == 13) chk("b2b_tail_idle", 32'(smp_valid), 32'h0);
        end
        chk("b2b_valid_cycles", 32'(nv), 32'd12);
        chk("b2b_cnt", 32'(smp_cnt), 32'(cnt_start + 16'h3));

        // Backpressure while B2 is presented.
        cycle(1'b0, 1'b1, 32'hA1B2C3D4, 1'b0, 2'd3, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
        chk("bp_a1", 32'(smp_data), 32'hA1);
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, 1'b1, 32'h55555555, 1'b0, 2'd3, 1'b0);
            chk("bp_hold_b2", 32'(smp_data), 32'hB2);
            chk("bp_hold_ready", 32'(smp_ready), 32'h0);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
        chk("bp_b2", 32'(smp_data), 32'hB2);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
        chk("bp_c3", 32'(smp_data), 32'hC3);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
        chk("bp_d4", 32'(smp_data), 32'hD4);
        chk("bp_d4_last", 32'(smp_last), 32'h1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);

        // Reset while C3 is presented, then a fresh word.
        cycle(1'b0, 1'b1, 32'hA1B2C3D4, 1'b0, 2'd3, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
        chk("mid_c3", 32'(smp_data), 32'hC3);
        cycle(1'b0, 1'b1, 32'h11223344, 1'b1, 2'd1, 1'b1);
        chk("mid_rst_valid", 32'(smp_valid), 32'h0);
        chk("mid_rst_cnt", 32'(smp_cnt), 32'h0);
        chk("mid_rst_ready", 32'(smp_ready), 32'h1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
        chk("post_rst_b0", 32'(smp_data), 32'h44);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
        chk("post_rst_b1", 32'(smp_data), 32'h33);
        chk("post_rst_last", 32'(smp_last), 32'h1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 3000; c++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0), $urandom(),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
        end

        // Counter wrap: 65536 single-byte words back to back.
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
        for (int c = 0; c < 65536; c++) begin
            cycle(1'b0, 1'b1, 32'(c) << 24, 1'b0, 2'd0, 1'b1);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
        chk("wrap_ffff", 32'(smp_cnt), 32'h0000FFFF);
        chk("wrap_last_byte", 32'(smp_data), 32'hFF);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
        chk("wrap_zero", 32'(smp_cnt), 32'h0);
        chk("wrap_idle", 32'(smp_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
